// File: rtl/addrdecode_skid.sv
// Registered address decoder with a two-entry skid buffer for the crossbar front end.
// Lowest-index matching slave wins; unmatched requests are forwarded with the no-slave bit set.
module addrdecode_skid #(
   parameter int NS = 8,
   parameter int AW = 32,
   parameter int DW = 38,
   parameter logic [NS*AW-1:0] SLAVE_ADDR = {
      32'hE0000000, 32'hC0000000, 32'hA0000000, 32'h80000000,
      32'h60000000, 32'h40000000, 32'h20000000, 32'h00000000},
   parameter logic [NS*AW-1:0] SLAVE_MASK = {
      32'hE0000000, 32'hE0000000, 32'hE0000000, 32'hE0000000,
      32'hE0000000, 32'hE0000000, 32'hF0000000, 32'hF0000000},
   parameter logic [NS-1:0] ACCESS_ALLOWED = '1,
   parameter bit OPT_LOWPOWER = 1'b0,
   parameter int ERRCNT_W = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_valid,
   output logic                o_stall,
   input  logic [AW-1:0]       i_addr,
   input  logic [DW-1:0]       i_data,
   output logic                o_valid,
   input  logic                i_stall,
   output logic [NS:0]         o_decode,
   output logic [AW-1:0]       o_addr,
   output logic [DW-1:0]       o_data,
   output logic [ERRCNT_W-1:0] o_err_count,
   output logic [AW-1:0]       o_err_addr
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      BUSY  = 2'b10,
      FULL  = 2'b11
   } StateType;

   StateType            r_state;
   logic                r_valid;
   logic                r_stall;
   logic [NS:0]         r_decode;
   logic [AW-1:0]       r_addr;
   logic [DW-1:0]       r_data;
   logic [NS:0]         r_skidDecode;
   logic [AW-1:0]       r_skidAddr;
   logic [DW-1:0]       r_skidData;
   logic [ERRCNT_W-1:0] r_errCount;
   logic [AW-1:0]       r_errAddr;

   logic [NS:0]         w_decode;
   logic                w_found;
   logic                w_accept;

   // Priority decode at the input; the first match found stops further matches.
   always_comb begin
      w_decode = '0;
      w_found  = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (!w_found && ACCESS_ALLOWED[k]
               && (((i_addr ^ SLAVE_ADDR[k*AW +: AW]) & SLAVE_MASK[k*AW +: AW]) == '0)) begin
            w_decode[k] = 1'b1;
            w_found     = 1'b1;
         end
      end
      if (!w_found)
         w_decode[NS] = 1'b1;
   end

   assign w_accept = i_valid && !r_stall;

   // Decode is cleared whenever OUT empties so that o_valid always equals (o_decode != 0).
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= EMPTY;
         r_valid      <= 1'b0;
         r_stall      <= 1'b0;
         r_decode     <= '0;
         r_addr       <= '0;
         r_data       <= '0;
         r_skidDecode <= '0;
         r_skidAddr   <= '0;
         r_skidData   <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  r_state  <= BUSY;
                  r_valid  <= 1'b1;
                  r_decode <= w_decode;
                  r_addr   <= i_addr;
                  r_data   <= i_data;
               end
            end
            BUSY: begin
               if (w_accept && !i_stall) begin
                  r_decode <= w_decode;
                  r_addr   <= i_addr;
                  r_data   <= i_data;
               end else if (w_accept && i_stall) begin
                  r_state      <= FULL;
                  r_stall      <= 1'b1;
                  r_skidDecode <= w_decode;
                  r_skidAddr   <= i_addr;
                  r_skidData   <= i_data;
               end else if (!i_stall) begin
                  r_state  <= EMPTY;
                  r_valid  <= 1'b0;
                  r_decode <= '0;
                  if (OPT_LOWPOWER) begin
                     r_addr <= '0;
                     r_data <= '0;
                  end
               end
            end
            FULL: begin
               if (!i_stall) begin
                  r_state  <= BUSY;
                  r_stall  <= 1'b0;
                  r_decode <= r_skidDecode;
                  r_addr   <= r_skidAddr;
                  r_data   <= r_skidData;
                  if (OPT_LOWPOWER) begin
                     r_skidDecode <= '0;
                     r_skidAddr   <= '0;
                     r_skidData   <= '0;
                  end
               end
            end
            default: begin
               r_state  <= EMPTY;
               r_valid  <= 1'b0;
               r_stall  <= 1'b0;
               r_decode <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_errCount <= '0;
         r_errAddr  <= '0;
      end else if (r_valid && !i_stall && r_decode[NS]) begin
         if (r_errCount != {ERRCNT_W{1'b1}})
            r_errCount <= r_errCount + {{(ERRCNT_W-1){1'b0}}, 1'b1};
         r_errAddr <= r_addr;
      end
   end

   assign o_valid     = r_valid;
   assign o_stall     = r_stall;
   assign o_decode    = r_decode;
   assign o_addr      = r_addr;
   assign o_data      = r_data;
   assign o_err_count = r_errCount;
   assign o_err_addr  = r_errAddr;

endmodule
